reg_share_arbiter: RTL and testbench
====================================

// Module: reg_share_arbiter
// PURPOSE
//  Shares one N-bit capture register between NREQ requesters.
//  Round-robin arbitration picks a requester, loads its data into the register
//  and presents it to a single consumer through a valid/ready handshake.
//  Sits between the requester-side datapaths and the shared register's downstream consumer.
// PARAMETERS
//  N        8   data width of each requester and of q
//  NREQ     4   number of requesters, >=2
//  TIMEOUT  16  HOLD cycles without q_ready before a drop (only with REG_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous, active-high reset
//  req          in   NREQ        per-requester request; held until its gnt bit is seen
//  req_data     in   NREQ*N      requester i data at [i*N +: N]; stable while req[i] is high
//  gnt          out  NREQ        one-hot, one-cycle pulse, registered on the capture edge
//  q            out  N           captured data
//  q_valid      out  1           q holds an unaccepted word
//  q_owner      out  clog2(NREQ) index of the requester that supplied q
//  q_ready      in   1           consumer accepts q on the edge where q_valid && q_ready
//  timeout_err  out  1           one-cycle pulse when a word is dropped; tied 0 without macro
// BEHAVIOUR
//  Reset (async assert, sync release) sets q=0, q_valid=0, gnt=0, q_owner=0,
//  timeout_err=0, rr_ptr=0, state=IDLE, timeout counter=0.
//  Eligible set: elig = req & ~gnt. A requester granted this cycle cannot win at the next edge.
//  Winner: first set bit of elig, searching from rr_ptr upward and wrapping past NREQ-1 to 0.
//  Capture edge: q<=req_data[w], q_owner<=w, q_valid<=1, gnt<=onehot(w), rr_ptr<=(w+1)%NREQ.
//  All other edges: gnt<=0.
//  FSM has two states:
//   IDLE: elig!=0 -> capture, go to HOLD; otherwise stay, with q retaining its last value.
//   HOLD: q_valid=1, q/q_owner stable.
//     q_ready && elig!=0 -> capture the next winner at the same edge, stay in HOLD.
//       This gives back-to-back throughput of one word per cycle.
//     q_ready && elig==0 -> q_valid<=0, go to IDLE.
//     !q_ready -> hold, no gnt.
//  Latency: req rising before edge k -> capture at edge k, gnt and q_valid visible in cycle k+1.
//  A single requester re-raising req immediately after gnt waits at least one cycle (mask rule).
//  Reset mid-HOLD: q_valid drops immediately (async); the unaccepted word is lost.
//    After release, pending requests are re-arbitrated from requester 0.
//  rr_ptr wraps from NREQ-1 to 0; NREQ that is not a power of two uses modulo wrap.
// CONFIGURATION
//  REG_ARB_TIMEOUT_EN defined:
//    A counter clears on each capture and increments every HOLD cycle with !q_ready.
//    At the edge where it reaches TIMEOUT: q_valid<=0, timeout_err<=1 for one cycle, go to IDLE.
//    rr_ptr is unchanged. q_ready on that same edge wins: the word is accepted, no error.
//  Not defined: no counter, HOLD waits indefinitely, timeout_err is constant 0.
// TESTING
//  1 reset=1 with req=4'hF -> q=0, q_valid=0, gnt=0, timeout_err=0; release with req=0
//    -> q_valid stays 0.
//  2 req=4'b0001, data0=8'hA5, q_ready=0 -> next cycle gnt=4'b0001 (one cycle only), q=8'hA5,
//    q_owner=0, q_valid=1; q stable 5 cycles; q_ready=1 -> q_valid=0 next cycle.
//  3 req=4'hF, data=11/22/33/44, q_ready=1, each req dropped after its gnt
//    -> q=11,22,33,44 on consecutive cycles, q_owner 0,1,2,3.
//    Then req0 again -> owner 0 (ptr wrapped).
//  4 req0 held high continuously, req2 high, q_ready=1 -> grants alternate 0,2,0,2;
//    req0 never wins two consecutive edges.
//  5 HOLD with q=8'h3C, reset pulsed mid-cycle -> q_valid=0 and q=0 before the next edge;
//    req=4'b1010 after release -> owner 1 first.
//  6 REG_ARB_TIMEOUT_EN, TIMEOUT=16, q_ready=0 -> q_valid falls 16 cycles after capture,
//    timeout_err high exactly 1 cycle.
//    Without the macro -> q_valid still 1 after 100 cycles.

Source files
------------

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that shares one capture register between NREQ requesters
// and hands the captured word to a single valid/ready consumer.
// Optional HOLD timeout: define REG_ARB_TIMEOUT_EN.
module reg_share_arbiter #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*N-1:0]         req_data,
  output logic [NREQ-1:0]           gnt,
  output logic [N-1:0]              q,
  output logic                      q_valid,
  output logic [$clog2(NREQ)-1:0]   q_owner,
  input  logic                      q_ready,
  output logic                      timeout_err
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state;
  logic [OW-1:0]   rr_ptr;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [OW-1:0]   win;
  logic [OW-1:0]   next_ptr;
  logic [NREQ-1:0] win_onehot;
  logic [OW:0]     sum;
  logic [OW-1:0]   idx;
  logic            capture;

  // A requester granted last edge is masked so it cannot win twice in a row.
  assign elig = req & ~gnt;

  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (OW+1)'(k);
      if (sum >= (OW+1)'(NREQ))
        sum = sum - (OW+1)'(NREQ);
      idx = sum[OW-1:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
  end

  assign next_ptr = (win == OW'(NREQ-1)) ? '0 : win + 1'b1;
  assign capture  = found && ((state == IDLE) || q_ready);

`ifdef REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      q           <= '0;
      q_valid     <= 1'b0;
      q_owner     <= '0;
      gnt         <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      gnt         <= '0;
      timeout_err <= 1'b0;
      if (capture) begin
        q       <= req_data[int'(win)*N +: N];
        q_owner <= win;
        q_valid <= 1'b1;
        gnt     <= win_onehot;
        rr_ptr  <= next_ptr;
        cnt     <= '0;
        state   <= HOLD;
      end else if (state == HOLD) begin
        if (q_ready) begin
          q_valid <= 1'b0;
          state   <= IDLE;
        end else if (cnt == CW'(TIMEOUT-1)) begin
          // Drop the stale word; the round-robin pointer is left untouched.
          cnt         <= cnt + 1'b1;
          q_valid     <= 1'b0;
          timeout_err <= 1'b1;
          state       <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
`else
  // TIMEOUT only matters when the timeout is compiled in.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end

  assign timeout_err = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      q       <= '0;
      q_valid <= 1'b0;
      q_owner <= '0;
      gnt     <= '0;
      rr_ptr  <= '0;
    end else begin
      gnt <= '0;
      if (capture) begin
        q       <= req_data[int'(win)*N +: N];
        q_owner <= win;
        q_valid <= 1'b1;
        gnt     <= win_onehot;
        rr_ptr  <= next_ptr;
        state   <= HOLD;
      end else if (state == HOLD && q_ready) begin
        q_valid <= 1'b0;
        state   <= IDLE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed self-checking bench for reg_share_arbiter (N=8, NREQ=4, TIMEOUT=16).
// Honours REG_ARB_TIMEOUT_EN for the timeout scenario.
module tb_reg_share_arbiter;
  localparam int N    = 8;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [N-1:0]      q;
  logic              q_valid;
  logic [1:0]        q_owner;
  logic              q_ready;
  logic              timeout_err;

  int checks   = 0;
  int failures = 0;

  reg_share_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .q(q), .q_valid(q_valid), .q_owner(q_owner),
    .q_ready(q_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [N-1:0] v);
    req_data[i*N +: N] = v;
  endtask

  logic [7:0] t3_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [1:0] t4_owner [4] = '{2'd2, 2'd0, 2'd2, 2'd0};

  initial begin
    // 1: reset state
    reset = 1'b1; req = 4'hF; req_data = '0; q_ready = 1'b0;
    #12;
    check("rst_q", q, 8'h00);
    check("rst_valid", q_valid, 1'b0);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_terr", timeout_err, 1'b0);
    req = 4'h0; reset = 1'b0;
    tick;
    check("rel_valid", q_valid, 1'b0);

    // 2: single requester, consumer stalls then accepts
    req = 4'b0001; set_data(0, 8'hA5);
    tick;
    check("t2_gnt", gnt, 4'b0001);
    check("t2_q", q, 8'hA5);
    check("t2_owner", q_owner, 2'd0);
    check("t2_valid", q_valid, 1'b1);
    req = 4'b0000;
    tick;
    check("t2_gnt_pulse", gnt, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("t2_q_stable", q, 8'hA5);
      check("t2_valid_stable", q_valid, 1'b1);
    end
    q_ready = 1'b1;
    tick;
    check("t2_accept", q_valid, 1'b0);
    q_ready = 1'b0;

    // return the pointer to requester 0
    #2 reset = 1'b1;
    #2 reset = 1'b0;

    // 3: all four request, back-to-back service in order
    for (int i = 0; i < 4; i++) set_data(i, t3_data[i]);
    req = 4'hF; q_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("t3_gnt", gnt, 32'(1) << i);
      check("t3_q", q, t3_data[i]);
      check("t3_owner", q_owner, i[1:0]);
      req[i] = 1'b0;
    end
    tick;
    check("t3_idle", q_valid, 1'b0);
    set_data(0, 8'h55); req = 4'b0001;
    tick;
    check("t3_wrap_owner", q_owner, 2'd0);
    check("t3_wrap_q", q, 8'h55);
    req = 4'b0000;
    tick;
    check("t3_wrap_idle", q_valid, 1'b0);

    // 4: req0 and req2 held continuously; rr_ptr=1 so 2 wins first
    set_data(0, 8'hA0); set_data(2, 8'hC2);
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("t4_owner", q_owner, t4_owner[i]);
      check("t4_gnt", gnt, 32'(1) << t4_owner[i]);
      check("t4_q", q, (t4_owner[i] == 2'd0) ? 8'hA0 : 8'hC2);
    end
    req = 4'b0000;
    tick;
    check("t4_idle", q_valid, 1'b0);

    // 5: reset while holding an unaccepted word
    q_ready = 1'b0; set_data(1, 8'h3C); req = 4'b0010;
    tick;
    check("t5_q", q, 8'h3C);
    check("t5_owner", q_owner, 2'd1);
    req = 4'b0000;
    tick;
    check("t5_hold", q_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_valid", q_valid, 1'b0);
    check("t5_async_q", q, 8'h00);
    check("t5_async_owner", q_owner, 2'd0);
    #1 reset = 1'b0;
    set_data(1, 8'h61); set_data(3, 8'h63); req = 4'b1010; q_ready = 1'b1;
    tick;
    check("t5_first_owner", q_owner, 2'd1);
    check("t5_first_q", q, 8'h61);
    check("t5_first_gnt", gnt, 4'b0010);
    req = 4'b1000;
    tick;
    check("t5_second_owner", q_owner, 2'd3);
    check("t5_second_q", q, 8'h63);
    req = 4'b0000;
    tick;
    check("t5_idle", q_valid, 1'b0);
    q_ready = 1'b0;

    // 6: consumer never ready
    set_data(0, 8'h5A); req = 4'b0001;
    tick;
    check("t6_capture", q_valid, 1'b1);
    req = 4'b0000;
`ifdef REG_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      tick;
      check("t6_wait_valid", q_valid, 1'b1);
      check("t6_wait_terr", timeout_err, 1'b0);
    end
    tick;
    check("t6_drop_valid", q_valid, 1'b0);
    check("t6_drop_terr", timeout_err, 1'b1);
    tick;
    check("t6_terr_pulse", timeout_err, 1'b0);
    check("t6_after_valid", q_valid, 1'b0);
`else
    repeat (100) tick;
    check("t6_still_valid", q_valid, 1'b1);
    check("t6_still_q", q, 8'h5A);
    check("t6_terr_zero", timeout_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
